// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 1024x768@60 timing constants and helpers
//
// Purpose: one place for the VGA timing defaults, the derived totals and the
// sync window bounds, so the timing source and every draw stage agree on
// the same geometry.
// Ports: none (package).
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [11:0] BG_COLOR = 12'h000;

    // RESET: the cycle after rst, which presents pixel (0,0) without counting.
    typedef enum logic {
        SRC_RESET = 1'b0,
        SRC_RUN   = 1'b1
    } src_state_e;

    // Unsigned inclusive window test on a counter value.
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one VGA axis: counter plus registered sync/blank
//
// Purpose: counts 0..ACTIVE+FP+SYNC+BP-1 and registers sync/blank decoded
// from the next count, so flags and count always change on the same edge.
// Ports:
//   pclk, rst    clock, synchronous active-high reset
//   start        force the next count to 0 (first cycle after reset)
//   enable       advance the count this cycle
//   count        registered count
//   count_next   value count takes on the next edge
//   sync, blank  registered flags matching count
//   wrap         count is at its last value and enabled (wraps this edge)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = vga_pkg::H_ACTIVE,
    parameter int FP     = vga_pkg::H_FP,
    parameter int SYNC   = vga_pkg::H_SYNC,
    parameter int BP     = vga_pkg::H_BP
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             sync,
    output logic             blank,
    output logic             wrap
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC - 1;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C = CNT_W'(ACTIVE);

    assign wrap = enable && !start && (count == LAST);

    always_comb begin
        count_next = count;
        if (start) begin
            count_next = '0;
        end else if (wrap) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            count <= '0;
            sync  <= 1'b0;
            blank <= 1'b0;
        end else begin
            count <= count_next;
            sync  <= in_window(count_next, SYNC_START, SYNC_END);
            blank <= (count_next >= ACTIVE_C);
        end
    end

endmodule

// File: rtl/vga_timing_src.sv
// rtl/vga_timing_src.sv - VGA timing source with background rgb and frame_start
//
// Purpose: head of the pixel stream; produces counts, syncs, blanks, a
// background colour during active video and a one-cycle frame_start at (0,0).
// Every output is a flop.
// Ports:
//   pclk                      pixel clock
//   rst                       synchronous active-high reset
//   hcount_out, vcount_out    pixel / line index
//   hsync_out, vsync_out      active-high syncs
//   hblnk_out, vblnk_out      blanking flags
//   rgb_out                   BG_COLOR in active video, else 0
//   frame_start               high while (0,0) is presented
module vga_timing_src
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int          H_FP     = vga_pkg::H_FP,
    parameter int          H_SYNC   = vga_pkg::H_SYNC,
    parameter int          H_BP     = vga_pkg::H_BP,
    parameter int          V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int          V_FP     = vga_pkg::V_FP,
    parameter int          V_SYNC   = vga_pkg::V_SYNC,
    parameter int          V_BP     = vga_pkg::V_BP,
    parameter logic [11:0] BG_COLOR = vga_pkg::BG_COLOR
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);

    src_state_e       state, state_next;
    logic             start;
    logic [CNT_W-1:0] h_next, v_next;
    logic             h_wrap, v_wrap;
    logic             active_next;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= SRC_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Reset leaves the counters at (0,0) with flags cleared; the first free
    // edge re-presents (0,0) with live flags instead of skipping to (1,0).
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            SRC_RESET: begin
                start      = 1'b1;
                state_next = SRC_RUN;
            end
            SRC_RUN: begin
                state_next = SRC_RUN;
            end
            default: begin
                state_next = SRC_RESET;
            end
        endcase
    end

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP)
    ) u_h_axis (
        .pclk      (pclk),
        .rst       (rst),
        .start     (start),
        .enable    (1'b1),
        .count     (hcount_out),
        .count_next(h_next),
        .sync      (hsync_out),
        .blank     (hblnk_out),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP)
    ) u_v_axis (
        .pclk      (pclk),
        .rst       (rst),
        .start     (start),
        .enable    (h_wrap),
        .count     (vcount_out),
        .count_next(v_next),
        .sync      (vsync_out),
        .blank     (vblnk_out),
        .wrap      (v_wrap)
    );

    assign active_next = (h_next < H_ACTIVE_C) && (v_next < V_ACTIVE_C);

    // The next position is (0,0) either on the post-reset edge or when the
    // vertical axis wraps (which only happens together with the horizontal).
    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_out     <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            rgb_out     <= active_next ? BG_COLOR : 12'h000;
            frame_start <= start || v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_src.sv
// tb/tb_vga_timing_src.sv - self-checking bench for vga_timing_src
module tb_vga_timing_src;

    localparam logic [11:0] BG_F = 12'hf00;
    localparam logic [11:0] BG_S = 12'h5a3;
    localparam int SHA = 16, SHF = 2, SHS = 4, SHB = 3;
    localparam int SVA = 12, SVF = 1, SVS = 2, SVB = 3;
    localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
    } bundle_t;

    typedef struct {
        bit      sel;
        int      k;
        bundle_t exp;
    } vec_t;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst_f, rst_s;
    logic [10:0] hc_f, vc_f, hc_s, vc_s;
    logic hs_f, hb_f, vs_f, vb_f, fs_f, hs_s, hb_s, vs_s, vb_s, fs_s;
    logic [11:0] rgb_f, rgb_s;
    bundle_t act_f, act_s;

    assign act_f = {hc_f, vc_f, hs_f, hb_f, vs_f, vb_f, rgb_f, fs_f};
    assign act_s = {hc_s, vc_s, hs_s, hb_s, vs_s, vb_s, rgb_s, fs_s};

    vga_timing_src #(.BG_COLOR(BG_F)) dut_full (
        .pclk(pclk), .rst(rst_f),
        .hcount_out(hc_f), .hsync_out(hs_f), .hblnk_out(hb_f),
        .vcount_out(vc_f), .vsync_out(vs_f), .vblnk_out(vb_f),
        .rgb_out(rgb_f), .frame_start(fs_f)
    );

    vga_timing_src #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .BG_COLOR(BG_S)
    ) dut_small (
        .pclk(pclk), .rst(rst_s),
        .hcount_out(hc_s), .hsync_out(hs_s), .hblnk_out(hb_s),
        .vcount_out(vc_s), .vsync_out(vs_s), .vblnk_out(vb_s),
        .rgb_out(rgb_s), .frame_start(fs_s)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: position p counts presented pixels since the first
    // post-reset cycle; in_rst means reset values are on the outputs.
    bit f_rst_st = 1'b0, s_rst_st = 1'b0, armed_f = 1'b0, armed_s = 1'b0;
    int f_p = 0, s_p = 0;

    function automatic bundle_t bun(input int h, input int v, input bit hs, input bit hb,
                                    input bit vs, input bit vb, input logic [11:0] rgb,
                                    input bit fs);
        bundle_t r;
        r.h = 11'(h); r.v = 11'(v);
        r.hs = hs; r.hb = hb; r.vs = vs; r.vb = vb;
        r.rgb = rgb; r.fs = fs;
        return r;
    endfunction

    function automatic vec_t mk(input bit sel, input int k, input int h, input int v,
                                input bit hs, input bit hb, input bit vs, input bit vb,
                                input logic [11:0] rgb, input bit fs);
        vec_t t;
        t.sel = sel;
        t.k   = k;
        t.exp = bun(h, v, hs, hb, vs, vb, rgb, fs);
        return t;
    endfunction

    function automatic bundle_t ref_bundle(input bit in_rst, input int p,
                                           input int ha, input int hf, input int hsw, input int hbp,
                                           input int va, input int vf, input int vsw, input int vbp,
                                           input logic [11:0] bg);
        bundle_t r;
        int ht, vt, h, v;
        r = '0;
        if (in_rst) return r;
        ht = ha + hf + hsw + hbp;
        vt = va + vf + vsw + vbp;
        h = p % ht;
        v = (p / ht) % vt;
        r.h   = 11'(h);
        r.v   = 11'(v);
        r.hb  = (h >= ha);
        r.hs  = (h >= ha + hf) && (h < ha + hf + hsw);
        r.vb  = (v >= va);
        r.vs  = (v >= va + vf) && (v < va + vf + vsw);
        r.rgb = (!r.hb && !r.vb) ? bg : 12'h000;
        r.fs  = (h == 0) && (v == 0);
        return r;
    endfunction

    task automatic check(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b rgb=%h fs=%b want h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b rgb=%h fs=%b",
                     name, act.h, act.v, act.hs, act.hb, act.vs, act.vb, act.rgb, act.fs,
                     exp.h, exp.v, exp.hs, exp.hb, exp.vs, exp.vb, exp.rgb, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        if (rst_f) begin f_rst_st = 1'b1; armed_f = 1'b1; end
        else if (f_rst_st) begin f_rst_st = 1'b0; f_p = 0; end
        else f_p++;
        if (rst_s) begin s_rst_st = 1'b1; armed_s = 1'b1; end
        else if (s_rst_st) begin s_rst_st = 1'b0; s_p = 0; end
        else s_p++;
        #1;
        if (armed_f)
            check("cyc_full", act_f,
                  ref_bundle(f_rst_st, f_p, 1024, 24, 136, 160, 768, 3, 6, 29, BG_F));
        if (armed_s)
            check("cyc_small", act_s,
                  ref_bundle(s_rst_st, s_p, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, BG_S));
    endtask

    vec_t vecs[$];

    initial begin
        int k;
        int guard;
        int fs_cnt;
        rst_f = 1'b1;
        rst_s = 1'b1;

        // k = cycles after reset release; sel 0 = full timing, 1 = small timing
        vecs.push_back(mk(0,    1,    0, 0, 0, 0, 0, 0, BG_F,   1));
        vecs.push_back(mk(1,    1,    0, 0, 0, 0, 0, 0, BG_S,   1));
        vecs.push_back(mk(0,    2,    1, 0, 0, 0, 0, 0, BG_F,   0));
        vecs.push_back(mk(1,   17,   16, 0, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(1,   19,   18, 0, 1, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(1,   22,   21, 0, 1, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(1,   23,   22, 0, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(1,   26,    0, 1, 0, 0, 0, 0, BG_S,   0));
        vecs.push_back(mk(1,  291,   15, 11, 0, 0, 0, 0, BG_S,  0));
        vecs.push_back(mk(1,  300,   24, 11, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(1,  301,    0, 12, 0, 0, 0, 1, 12'h000, 0));
        vecs.push_back(mk(1,  326,    0, 13, 0, 0, 1, 1, 12'h000, 0));
        vecs.push_back(mk(1,  375,   24, 14, 0, 1, 1, 1, 12'h000, 0));
        vecs.push_back(mk(1,  376,    0, 15, 0, 0, 0, 1, 12'h000, 0));
        vecs.push_back(mk(1,  450,   24, 17, 0, 1, 0, 1, 12'h000, 0));
        vecs.push_back(mk(1,  451,    0, 0, 0, 0, 0, 0, BG_S,   1));
        vecs.push_back(mk(1,  452,    1, 0, 0, 0, 0, 0, BG_S,   0));
        vecs.push_back(mk(0, 1024, 1023, 0, 0, 0, 0, 0, BG_F,   0));
        vecs.push_back(mk(0, 1025, 1024, 0, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(0, 1048, 1047, 0, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(0, 1049, 1048, 0, 1, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(0, 1184, 1183, 0, 1, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(0, 1185, 1184, 0, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(0, 1344, 1343, 0, 0, 1, 0, 0, 12'h000, 0));
        vecs.push_back(mk(0, 1345,    0, 1, 0, 0, 0, 0, BG_F,   0));

        repeat (3) tick();
        check("reset_full", act_f, '0);
        check("reset_small", act_s, '0);

        rst_f = 1'b0;
        rst_s = 1'b0;
        k = 0;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) begin
                tick();
                k++;
            end
            check($sformatf("vec%0d_%s_k%0d", i, vecs[i].sel ? "small" : "full", vecs[i].k),
                  vecs[i].sel ? act_s : act_f, vecs[i].exp);
        end

        // Mid-frame reset at small-timing pixel (10,7).
        guard = 0;
        while ((s_p % S_FRAME) != 185 && guard < 2 * S_FRAME) begin
            tick();
            guard++;
        end
        check_int("midreset_reach", s_p % S_FRAME, 185);
        rst_s = 1'b1;
        tick();
        check("midreset_zero", act_s, '0);
        rst_s = 1'b0;
        tick();
        check("midreset_first", act_s, bun(0, 0, 0, 0, 0, 0, BG_S, 1));
        tick();
        check("midreset_second", act_s, bun(1, 0, 0, 0, 0, 0, BG_S, 0));

        // Exactly one frame_start per frame over two frames.
        fs_cnt = 0;
        repeat (2 * S_FRAME) begin
            tick();
            if (fs_s === 1'b1) fs_cnt++;
        end
        check_int("frame_start_count", fs_cnt, 2);

        // Random reset pulses against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rst_f = ($urandom_range(0, 299) == 0);
            rst_s = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst_f = 1'b0;
        rst_s = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_src.md
Name: vga_timing_src

Overview:
- Source end of the VGA pixel stream that every draw stage in the chain consumes.
- Generates the hcount/vcount, hsync/vsync and hblnk/vblnk bundle for 1024x768@60 on a 65 MHz pclk.
- Seeds rgb with a background colour.
- Adds a one-cycle frame_start pulse for the game logic, so square-highlight updates land between frames.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels); line total 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines); frame total 806
- BG_COLOR, 12'h0_0_0, rgb_out during active video

Ports:
- pclk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-high reset
- hcount_out  out  11  horizontal pixel index, 0..1343
- hsync_out  out  1  horizontal sync, active-high
- hblnk_out  out  1  horizontal blank
- vcount_out  out  11  vertical line index, 0..805
- vsync_out  out  1  vertical sync, active-high
- vblnk_out  out  1  vertical blank
- rgb_out  out  12  background pixel, 4:4:4
- frame_start  out  1  one-cycle pulse when hcount_out==0 and vcount_out==0

Behaviour:
- Interface: one clock (pclk); reset rst is synchronous and active-high.
- All outputs are flops. No combinational path from any input to any output.
- Reset (rst high at a pclk edge), registered values:
  - hcount_out = 0, vcount_out = 0
  - hsync_out, vsync_out, hblnk_out, vblnk_out = 0
  - rgb_out = 0
  - frame_start = 0
- First cycle after rst deasserts:
  - outputs show pixel (0,0)
  - frame_start = 1
  - rgb_out = BG_COLOR
- Horizontal counter:
  - increments every cycle
  - at 1343 (H_TOTAL-1) it wraps to 0
- Vertical counter:
  - increments only on the cycle hcount wraps
  - at 805 it wraps to 0 on the same edge hcount wraps
- Output invariants, which hold in every non-reset cycle for the currently presented hcount_out/vcount_out:
  - hblnk_out = (hcount_out >= 1024)
  - hsync_out = (1048 <= hcount_out <= 1183)
  - vblnk_out = (vcount_out >= 768)
  - vsync_out = (771 <= vcount_out <= 776)
  - rgb_out = BG_COLOR when neither blank is set, else 12'h000
  - frame_start = (hcount_out==0 && vcount_out==0)
- Implementation rule: decode flags from the next-count values and register them alongside the counters. This gives zero skew between count and flags.
- Latency: the stream has no input, so there is no latency. Downstream stages each add exactly one cycle to the whole bundle, so the bundle alignment must be exact.
- Width rule: 11-bit counters. All comparisons are unsigned and must be computed from parameters, never hard-coded. The literal values above are for the default parameters only.
- Reset mid-line or mid-frame: on the next edge, counters jump to 0,0 and all flags clear. The first post-reset cycle is a full frame_start. No partial-frame pulse is generated.
- Both-counter wrap (hcount 1343, vcount 805 → 0,0): vblnk falls, hblnk falls, and frame_start rises, all on the same edge.

Decomposition:
- Shared package vga_pkg holds the defaults H_ACTIVE..V_BP, derived H_TOTAL/V_TOTAL, and the sync start/end constants. The draw stages use the same constants for square geometry (board columns 0..343, 344..679, 680..1023).
- One natural sub-module, vga_axis_counter:
  - parameters ACTIVE/FP/SYNC/BP
  - inputs: enable, wrap-out
  - outputs: count, sync, blank
  - instantiated twice: horizontal axis enabled every cycle, vertical axis enabled by the horizontal wrap.

Test Plan:
- Reset release: hold rst 3 cycles, then release → cycle 1: hcount=0, vcount=0, frame_start=1, all syncs/blanks 0, rgb_out=BG_COLOR. Cycle 2: hcount=1, frame_start=0.
- Line timing: run one line → hblnk rises at hcount=1024; hsync high exactly for hcount 1048..1183 (136 cycles); hcount 1343 is followed by 0 with vcount+1; line length 1344 cycles.
- Frame timing: run 2 frames → vblnk covers vcount 768..805; vsync covers 771..776 (6 lines, 8064 cycles); frame_start pulses every 1,083,264 cycles, exactly once per frame.
- Rgb gating: BG_COLOR=12'hf_0_0 → rgb_out=12'hf00 at (0,0) and (1023,767); rgb_out=12'h000 at (1024,0) and (0,768).
- Mid-frame reset: assert rst for 1 cycle at (500,300) → next cycle all outputs 0; the cycle after shows (0,0) with frame_start=1; no pulse at (0,0) is missed or duplicated.
- Chain alignment: drive one draw stage configured for square 344..679, v≤251 with select=1 → highlight colour appears at the stage output for exactly hcount_out 344..679 in lines 0..251, with zero pixel offset.
